// File: rtl/alu_op_seq_if.sv
// Decoder-to-sequencer operation handshake for the ALU operand path.
// The decoder drives the master side and the sequencer owns op_ready on the slave side.
interface alu_op_seq_if #(
    parameter int DW = 8
);
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    op_code;
    logic [1:0]    op_src;
    logic [1:0]    op_dst;
    logic [DW-1:0] op_operand;
    logic          d_flag;

    modport master (
        output op_valid,
        output op_code,
        output op_src,
        output op_dst,
        output op_operand,
        output d_flag,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_code,
        input  op_src,
        input  op_dst,
        input  op_operand,
        input  d_flag,
        output op_ready
    );
endinterface

// File: rtl/alu_op_seq.sv
// Micro-sequencer issuing AI/BI load, execute and writeback strobes for one ALU operation.
// Optional decimal-adjust step is built only when ALU_SEQ_BCD_EN is defined.
module alu_op_seq #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    alu_op_seq_if.slave   op,
    output logic          AI_load,
    output logic [1:0]    AI_sel,
    output logic          BI_load,
    output logic [1:0]    BI_sel,
    output logic [DW-1:0] BI_data,
    output logic          alu_en,
    output logic [3:0]    alu_op,
    output logic [2:0]    dest_load,
    output logic          flags_load,
    output logic          done,
    output logic          err,
    output logic          busy
);

    localparam logic [3:0] OP_ADC  = 4'd0;
    localparam logic [3:0] OP_SBC  = 4'd1;
    localparam logic [3:0] OP_ORA  = 4'd3;
    localparam logic [3:0] OP_CMP  = 4'd5;
    localparam logic [3:0] OP_INC  = 4'd6;
    localparam logic [3:0] OP_DEC  = 4'd7;
    localparam logic [3:0] OP_XFER = 4'd8;
    localparam logic [3:0] OP_DADJ = 4'hA;

`ifdef ALU_SEQ_BCD_EN
    typedef enum logic [2:0] {IDLE, LD_AI, LD_BI, EXEC, DADJ, WB} state_t;
`else
    typedef enum logic [2:0] {IDLE, LD_AI, LD_BI, EXEC, WB} state_t;
`endif

    state_t state;
    state_t next_state;

    logic [3:0] code_q;
    logic [1:0] src_q;
    logic [1:0] dst_q;
    logic       reject_q;
`ifdef ALU_SEQ_BCD_EN
    logic       dflag_q;
`else
    logic       unused_d_flag;
    assign unused_d_flag = op.d_flag;
`endif

    logic       accept;
    logic       illegal;
    logic       ai_load_n;
    logic [1:0] ai_sel_n;
    logic       bi_load_n;
    logic [1:0] bi_sel_n;
    logic       alu_en_n;
    logic [3:0] alu_op_n;
    logic [2:0] dest_load_n;
    logic       flags_load_n;
    logic       done_n;

    // INC/DEC/XFER reuse the adder and OR paths with a constant B operand.
    function automatic logic [3:0] map_op(input logic [3:0] code);
        case (code)
            OP_INC:  map_op = OP_ADC;
            OP_DEC:  map_op = OP_SBC;
            OP_XFER: map_op = OP_ORA;
            default: map_op = code;
        endcase
    endfunction

    function automatic logic [2:0] dest_onehot(input logic [1:0] dst, input logic [3:0] code);
        dest_onehot = 3'b000;
        if (code != OP_CMP) begin
            case (dst)
                2'd0:    dest_onehot = 3'b001;
                2'd1:    dest_onehot = 3'b010;
                2'd2:    dest_onehot = 3'b100;
                default: dest_onehot = 3'b000;
            endcase
        end
    endfunction

    assign accept  = op.op_valid && op.op_ready;
    assign illegal = (op.op_code > OP_XFER) || (op.op_src == 2'd3);

    // Strobes decoded here are registered below, so each appears the cycle after its state.
    always_comb begin
        next_state   = state;
        ai_load_n    = 1'b0;
        ai_sel_n     = 2'd0;
        bi_load_n    = 1'b0;
        bi_sel_n     = 2'd0;
        alu_en_n     = 1'b0;
        alu_op_n     = 4'd0;
        dest_load_n  = 3'b000;
        flags_load_n = 1'b0;
        done_n       = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !illegal) begin
                    next_state = LD_AI;
                end
            end
            LD_AI: begin
                ai_load_n  = 1'b1;
                ai_sel_n   = src_q;
                next_state = LD_BI;
            end
            LD_BI: begin
                bi_load_n = 1'b1;
                if (code_q == OP_INC || code_q == OP_DEC) begin
                    bi_sel_n = 2'd1;
                end else if (code_q == OP_XFER) begin
                    bi_sel_n = 2'd2;
                end
                next_state = EXEC;
            end
            EXEC: begin
                alu_en_n = 1'b1;
                alu_op_n = map_op(code_q);
`ifdef ALU_SEQ_BCD_EN
                if (dflag_q && (code_q == OP_ADC || code_q == OP_SBC)) begin
                    next_state = DADJ;
                end else begin
                    next_state = WB;
                end
`else
                next_state = WB;
`endif
            end
`ifdef ALU_SEQ_BCD_EN
            DADJ: begin
                alu_en_n   = 1'b1;
                alu_op_n   = OP_DADJ;
                next_state = WB;
            end
`endif
            WB: begin
                dest_load_n  = dest_onehot(dst_q, code_q);
                flags_load_n = 1'b1;
                done_n       = 1'b1;
                next_state   = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Illegal accepts leave the state in IDLE; reject_q delays err to line up with where AI_load would be.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op.op_ready <= 1'b1;
            busy        <= 1'b0;
            AI_load     <= 1'b0;
            AI_sel      <= 2'd0;
            BI_load     <= 1'b0;
            BI_sel      <= 2'd0;
            BI_data     <= '0;
            alu_en      <= 1'b0;
            alu_op      <= 4'd0;
            dest_load   <= 3'b000;
            flags_load  <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            reject_q    <= 1'b0;
            code_q      <= 4'd0;
            src_q       <= 2'd0;
            dst_q       <= 2'd0;
`ifdef ALU_SEQ_BCD_EN
            dflag_q     <= 1'b0;
`endif
        end else begin
            state       <= next_state;
            op.op_ready <= (next_state == IDLE);
            busy        <= (next_state != IDLE);
            AI_load     <= ai_load_n;
            AI_sel      <= ai_sel_n;
            BI_load     <= bi_load_n;
            BI_sel      <= bi_sel_n;
            alu_en      <= alu_en_n;
            alu_op      <= alu_op_n;
            dest_load   <= dest_load_n;
            flags_load  <= flags_load_n;
            done        <= done_n;
            err         <= reject_q;
            reject_q    <= accept && illegal;
            if (accept) begin
                code_q  <= op.op_code;
                src_q   <= op.op_src;
                dst_q   <= op.op_dst;
                BI_data <= op.op_operand;
`ifdef ALU_SEQ_BCD_EN
                dflag_q <= op.d_flag;
`endif
            end
        end
    end

endmodule

// File: doc/alu_op_seq.md
# alu_op_seq

Micro-sequencer for the ALU operand path of the CPU core. It accepts one register-level ALU operation per handshake and issues the strobes for each step in order: load the A input register, load the B input register, execute, optional decimal adjust, then writeback and flag update. It sits between the instruction decoder and the AI/BI/ALU/register-file datapath. It is the only driver of `AI_load`/`AI_sel` in the core.

## Interface
Parameters:
- `DW`, 8: datapath width; used only for `op_operand` passthrough.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `op_valid`  in  1  decoder presents an operation
- `op_ready`  out  1  sequencer can accept; high only in IDLE
- `op_code`  in  4  0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 CMP, 6 INC, 7 DEC, 8 XFER; 9–15 illegal
- `op_src`  in  2  AI source: 0 ACC, 1 X, 2 Y, 3 illegal
- `op_dst`  in  2  writeback target: 0 ACC, 1 X, 2 Y, 3 none
- `op_operand`  in  DW  B-operand data from the operand bus
- `d_flag`  in  1  processor decimal flag
- `AI_load`  out  1  load the A input register
- `AI_sel`  out  2  A input source, same encoding as `op_src`
- `BI_load`  out  1  load the B input register
- `BI_sel`  out  2  0 operand bus, 1 constant 1, 2 constant 0
- `BI_data`  out  DW  registered copy of `op_operand`
- `alu_en`  out  1  ALU execute strobe
- `alu_op`  out  4  ALU function; equals the latched `op_code`; INC maps to ADC (0), DEC maps to SBC (1), XFER maps to ORA (3)
- `dest_load`  out  3  one-hot writeback strobe {Y,X,ACC}
- `flags_load`  out  1  update N/Z (and C/V for ADC/SBC/CMP/INC/DEC)
- `done`  out  1  one-cycle pulse when the operation completes
- `err`  out  1  one-cycle pulse when an illegal operation is rejected
- `busy`  out  1  high when not in IDLE

## Operation
- States: IDLE, LD_AI, LD_BI, EXEC, DADJ (only with the macro), WB.
- Accept:
  - An operation is accepted when `op_valid && op_ready`.
  - On accept, `op_code`, `op_src`, `op_dst`, `op_operand` and `d_flag` are latched. Later input changes are ignored until the next IDLE.
- Illegal operation (`op_code` ≥ 9 or `op_src` == 3):
  - `err` pulses on the cycle after accept.
  - The sequencer stays in IDLE and issues no load, execute or writeback strobes.
- LD_AI:
  - `AI_load`=1, `AI_sel`=latched `op_src`.
- LD_BI:
  - `BI_load`=1.
  - `BI_sel` is 1 for INC/DEC, 2 for XFER, and 0 otherwise.
- EXEC:
  - `alu_en`=1, `alu_op` is the mapped function.
- DADJ:
  - Entered from EXEC only when the macro is defined, the latched `d_flag` is 1, and the operation is ADC or SBC.
  - `alu_en`=1 and `alu_op`=4'hA (decimal adjust).
- WB:
  - `dest_load` is the one-hot of the latched `op_dst`, or 0 when `op_dst`=3 or the operation is CMP.
  - `flags_load`=1 and `done`=1.
  - Next state is IDLE.
- All strobes are registered and last exactly one cycle. `alu_op` is 0 outside EXEC/DADJ. `AI_sel`/`BI_sel` are 0 outside their load states.
- Reset outputs: all outputs are 0 except `op_ready`=1. The state is IDLE.
- Reset mid-operation:
  - The cycle after reset asserts, the sequencer is in IDLE with all strobes 0.
  - No `done` is produced for the aborted operation.
- `op_valid` while busy is not accepted. The decoder must hold it until `op_ready`.

## Timing
- Cycle 0 = accept edge.
- AI load at cycle 1, BI load at 2, EXEC at 3, WB/`done` at 4.
- With DADJ: DADJ at 4, WB/`done` at 5.
- `op_ready` returns to 1 in the cycle after WB. The earliest back-to-back accept is therefore cycle 5 (or 6 with DADJ).
- Illegal operation: `err` at cycle 1, `op_ready` stays 1 throughout.

## Configuration
- Macro: `ALU_SEQ_BCD_EN`.
- Defined: the DADJ state exists, and ADC/SBC with the latched `d_flag`=1 take 5 cycles from accept to `done`.
- Undefined: there is no DADJ state, `d_flag` is ignored, and every legal operation takes 4 cycles. `alu_op` 4'hA is never issued.

## Test plan
- Reset: hold `reset` high for 2 cycles with `op_valid`=1 -> `op_ready`=1, all strobes 0, no accept during reset.
- ADC, `op_src`=X, `op_dst`=ACC, `d_flag`=0 -> `AI_load` with `AI_sel`=1 at cycle 1; `BI_load` with `BI_sel`=0 at 2; `alu_en` with `alu_op`=0 at 3; `dest_load`=3'b001, `flags_load` and `done` at 4.
- INC Y (`op_code`=6, `op_src`=2, `op_dst`=2) followed immediately by CMP -> first op: `BI_sel`=1 and `dest_load`=3'b100 at cycle 4; second op accepted at cycle 5; its WB has `dest_load`=0 and `flags_load`=1.
- SBC with `d_flag`=1 -> with `ALU_SEQ_BCD_EN`, `alu_op`=4'hA at cycle 4 and `done` at 5; without the macro, `done` at 4 and no 4'hA.
- `op_code`=12 or `op_src`=3 -> `err` pulse at cycle 1, no `AI_load`/`BI_load`/`alu_en`/`dest_load`, `busy` stays 0.
- Reset asserted during EXEC -> next cycle IDLE, `op_ready`=1, no `dest_load` and no `done`.
